mem_access_unit: RTL

Parametrised, registered MEM-stage memory sequencer for the RV32I core. It moves LB/LBU/LH/LHU/LW and SB/SH/SW traffic over the byte-wide RAM port, one byte per cycle. Read addresses are pipelined, so a load costs N+READ_LATENCY+1 cycles rather than 2N. It sits between the EX/MEM latch and MEM/WB, requests pipeline stall while busy, and passes non-memory results straight through.

---
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-serial MEM-stage load/store sequencer with pipelined reads.
// Optional misalignment trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  req_i,
    input  logic                  is_store_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           store_data_i,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [7:0]            mem_data_i,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [7:0]            mem_data_o,
    output logic                  stall_req_o,
    output logic                  done_o,
    output logic                  err_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e                  state_q, state_d;
    logic                    is_store_q, unsigned_q, err_q;
    logic [1:0]              size_q, last_q, cnt_q, cnt_nxt, last_in;
    logic [4:0]              wd_q;
    logic [31:0]             sdata_q, rdata_q, ext;
    logic [ADDR_WIDTH-1:0]   base_q, mem_addr_q;
    logic [7:0]              mem_wdata_q;
    logic [READ_LATENCY-1:0] pv_q;
    logic [1:0]              pl_q [READ_LATENCY];
    logic                    accept, misalign, cap_last;

    assign accept   = rdy && req_i && (state_q == IDLE);
    assign last_in  = (size_i == 2'd0) ? 2'd0 : (size_i == 2'd1) ? 2'd1 : 2'd3;
    assign cnt_nxt  = cnt_q + 2'd1;
    assign cap_last = pv_q[READ_LATENCY-1] && (pl_q[READ_LATENCY-1] == last_q);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ((size_i == 2'd1) && addr_i[0]) ||
                      (size_i[1] && (addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            unique case (state_q)
                IDLE:  if (req_i) state_d = misalign ? DONE : ISSUE;
                ISSUE: if (cnt_q == last_q) state_d = is_store_q ? DONE : DRAIN;
                DRAIN: if (cap_last) state_d = DONE;
                DONE:  state_d = IDLE;
            endcase
        end
    end

    // Each load beat is tagged with its lane and surfaces READ_LATENCY cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q  <= 1'b0;
            unsigned_q  <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'd0;
            last_q      <= 2'd0;
            cnt_q       <= 2'd0;
            wd_q        <= 5'd0;
            sdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            pv_q        <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pl_q[i] <= 2'd0;
        end else if (rdy) begin
            pv_q[0] <= (state_q == ISSUE) && !is_store_q;
            pl_q[0] <= cnt_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
            if (pv_q[READ_LATENCY-1])
                rdata_q[{pl_q[READ_LATENCY-1], 3'b000} +: 8] <= mem_data_i;
            if (accept) begin
                is_store_q <= is_store_i;
                unsigned_q <= unsigned_i;
                err_q      <= misalign;
                size_q     <= size_i;
                last_q     <= last_in;
                cnt_q      <= 2'd0;
                wd_q       <= wd_i;
                sdata_q    <= store_data_i;
                base_q     <= addr_i;
                if (!misalign) begin
                    mem_addr_q  <= addr_i;
                    mem_wdata_q <= store_data_i[7:0];
                end
            end else if (state_q == ISSUE && cnt_q != last_q) begin
                cnt_q       <= cnt_nxt;
                mem_addr_q  <= base_q + ADDR_WIDTH'(cnt_nxt);
                mem_wdata_q <= sdata_q[{cnt_nxt, 3'b000} +: 8];
            end
        end
    end

    always_comb begin
        ext = rdata_q;
        unique case (1'b1)
            (size_q == 2'd0): ext = {{24{!unsigned_q && rdata_q[7]}}, rdata_q[7:0]};
            (size_q == 2'd1): ext = {{16{!unsigned_q && rdata_q[15]}}, rdata_q[15:0]};
            default:          ext = rdata_q;
        endcase
    end

    always_comb begin
        wd_o        = 5'd0;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        stall_req_o = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    wd_o        = wd_i;
                    wreg_o      = wreg_i;
                    wdata_o     = wdata_i;
                    stall_req_o = req_i;
                end
                ISSUE, DRAIN: stall_req_o = 1'b1;
                DONE: begin
                    done_o = 1'b1;
                    err_o  = err_q;
                    if (!is_store_q && !err_q) begin
                        wd_o    = wd_q;
                        wreg_o  = 1'b1;
                        wdata_o = ext;
                    end
                end
            endcase
        end
    end

    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_wdata_q;
    assign mem_we_o   = rdy && (state_q == ISSUE) && is_store_q;
endmodule
